mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-ported ram between the cpu instruction-fetch port (port 0) and the load/store port (port 1). Sits between cpu and ram. Presents a ram-style request/ready handshake on each port and drives the ram's enable/read_or_write/addr/write_data. Round-robin on contention, with a watchdog that aborts stalled ram accesses.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max ACCESS cycles without mem_ready before abort; 0 disables watchdog
ABORT_DATA, 32'hDEADBEEF, read data returned on aborted read

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
p0_enable  in  1  fetch port request; held until p0_ready seen
p0_read_or_write  in  1  1=read, 0=write
p0_addr  in  AW  request address
p0_write_data  in  DW  write data
p0_read_data  out  DW  registered read data
p0_ready  out  1  one-cycle completion pulse
p1_enable, p1_read_or_write, p1_addr, p1_write_data, p1_read_data, p1_ready  as port 0, for the data port
mem_enable  out  1  ram enable
mem_read_or_write  out  1  to ram
mem_addr  out  AW  to ram
mem_write_data  out  DW  to ram
mem_read_data  in  DW  from ram
mem_ready  in  1  ram completion, sampled on clock
bus_error  out  1  sticky, set on watchdog abort
grant  out  1  port owning current access (valid when busy=1)
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; last_grant=1, so first tie goes to port 0; watchdog count=0; bus_error=0. Reset mid-access drops mem_enable immediately. The in-flight request is not completed; the requester re-issues after reset.
- Requester protocol: enable and fields held stable from assertion until the edge where ready=1 is sampled. Requester may deassert or issue a new request on the following cycle.
- IDLE:
  - No enable: stay.
  - One enable: grant that port.
  - Both enables: grant !last_grant.
  - On grant: register rw/addr/write_data into mem_* registers, set grant, go ACCESS.
- ACCESS:
  - mem_enable=1 with registered fields; count increments each cycle.
  - mem_ready=1 at edge: if read, capture mem_read_data into the granted port's read_data. Set last_grant=grant, clear count, go DONE.
  - TIMEOUT!=0 and count==TIMEOUT-1 without mem_ready: set bus_error. If read, load ABORT_DATA into the granted port's read_data. Go DONE.
  - mem_ready and timeout on the same edge: mem_ready wins, no error.
- DONE:
  - mem_enable=0; granted port's ready=1 for exactly this cycle; go IDLE.
  - The other port's ready stays 0.
- Latency: uncontended request sampled at edge N → ACCESS N+1. With mem_ready combinational-high, DONE (ready=1) at N+2. Minimum 3 cycles per access, including the return to IDLE.
- Write accesses leave port read_data unchanged. read_data holds its value until the next read on that port.
- Enable dropped by a requester while not granted: no effect. Enable dropped mid-ACCESS is a protocol violation; the access completes anyway.
- Starvation bound: under continuous contention, grants alternate strictly 0,1,0,1.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE, ACCESS, DONE), MEM_READ=1'b1 / MEM_WRITE=1'b0 constants, default ABORT_DATA.
- Single module with no sub-module required. Round-robin pick is a few lines of combinational logic inline.

Test Plan:
- p0 read addr 0x10, ram word 0x12345678, mem_ready tied 1 → p0_ready pulses 2 cycles after request edge; p0_read_data=0x12345678; p1 idle.
- p0 and p1 assert together after reset (p0 read 0x0, p1 write 0x40 data 0xCAFEF00D) → p0 served first, then p1. ram[0x40]=0xCAFEF00D; p1_read_data unchanged.
- Both ports held asserted for 6 accesses → grant sequence 0,1,0,1,0,1; no back-to-back grant to the same port.
- mem_ready held 0, TIMEOUT=8, p1 read → mem_enable high 8 cycles; then p1_ready=1, p1_read_data=0xDEADBEEF, bus_error=1 and remains 1 through later good accesses.
- reset asserted mid-ACCESS → mem_enable, busy, ready outputs 0 immediately (asynchronous). After release, the next tie grants port 0.
- CPU fetch plus load/store program running through the arbiter → identical architectural result to the direct cpu–ram connection; halts on the zero instruction.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the cpu/ram memory arbiter.
// Contents:
//   arb_state_e         - arbiter state encoding (IDLE, ACCESS, DONE)
//   MEM_READ/MEM_WRITE  - values carried on the read_or_write lines
//   DEFAULT_ABORT_DATA  - read data returned when the watchdog aborts a read
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that shares one single-ported ram between the
// cpu instruction-fetch port (port 0) and the load/store port (port 1).
// A watchdog aborts a ram access that stalls for too long.
// Ports:
//   clock, reset         - rising-edge clock, asynchronous active-low reset
//   pX_enable            - port request, held until pX_ready is seen
//   pX_read_or_write     - 1 = read, 0 = write
//   pX_addr, pX_write_data - request fields, held with pX_enable
//   pX_read_data         - registered read data, held until the next read
//   pX_ready             - one-cycle completion pulse
//   mem_*                - ram enable/read_or_write/addr/write_data, ram
//                          read data and ram completion
//   bus_error            - sticky, set on a watchdog abort
//   grant                - port owning the current access (valid when busy)
//   busy                 - arbiter is not idle
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              TIMEOUT    = 255,
  parameter logic [DW-1:0]   ABORT_DATA = DW'(DEFAULT_ABORT_DATA)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p0_enable,
  input  logic          p0_read_or_write,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_write_data,
  output logic [DW-1:0] p0_read_data,
  output logic          p0_ready,
  input  logic          p1_enable,
  input  logic          p1_read_or_write,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_write_data,
  output logic [DW-1:0] p1_read_data,
  output logic          p1_ready,
  output logic          mem_enable,
  output logic          mem_read_or_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  input  logic          mem_ready,
  output logic          bus_error,
  output logic          grant,
  output logic          busy
);

  // The counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] count_q, count_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          bus_error_q, bus_error_d;
  logic          pick;
  logic          timed_out;

  // Round robin: on a tie the port that did not win last time goes next;
  // otherwise whichever port is asking wins.
  assign pick = (p0_enable && p1_enable) ? ~last_grant_q : p1_enable;

  assign timed_out = (TIMEOUT != 0) && (count_q == COUNT_LAST);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    bus_error_d  = bus_error_q;

    case (state_q)
      IDLE: begin
        if (p0_enable || p1_enable) begin
          grant_d     = pick;
          mem_rw_d    = pick ? p1_read_or_write : p0_read_or_write;
          mem_addr_d  = pick ? p1_addr : p0_addr;
          mem_wdata_d = pick ? p1_write_data : p0_write_data;
          count_d     = '0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        count_d = count_q + 1'b1;
        // A completion on the same edge as the timeout wins over the abort.
        if (mem_ready) begin
          if (mem_rw_q == MEM_READ) begin
            if (grant_q) p1_rdata_d = mem_read_data;
            else         p0_rdata_d = mem_read_data;
          end
          last_grant_d = grant_q;
          count_d      = '0;
          state_d      = DONE;
        end else if (timed_out) begin
          // Aborted accesses still count as a turn so contention keeps
          // alternating between the ports.
          bus_error_d = 1'b1;
          if (mem_rw_q == MEM_READ) begin
            if (grant_q) p1_rdata_d = ABORT_DATA;
            else         p0_rdata_d = ABORT_DATA;
          end
          last_grant_d = grant_q;
          count_d      = '0;
          state_d      = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to port 1 so the first tie after reset goes to port 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign mem_enable        = (state_q == ACCESS);
  assign mem_read_or_write = mem_rw_q;
  assign mem_addr          = mem_addr_q;
  assign mem_write_data    = mem_wdata_q;
  assign p0_read_data      = p0_rdata_q;
  assign p1_read_data      = p1_rdata_q;
  assign p0_ready          = (state_q == DONE) && !grant_q;
  assign p1_ready          = (state_q == DONE) && grant_q;
  assign bus_error         = bus_error_q;
  assign grant             = grant_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural ram.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p0_enable = 1'b0, p0_read_or_write = 1'b0;
  logic [31:0] p0_addr = '0, p0_write_data = '0, p0_read_data;
  logic        p0_ready;
  logic        p1_enable = 1'b0, p1_read_or_write = 1'b0;
  logic [31:0] p1_addr = '0, p1_write_data = '0, p1_read_data;
  logic        p1_ready;
  logic        mem_enable, mem_read_or_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_ready;
  logic        bus_error, grant, busy;

  // Behavioural ram: combinational read, write on a completing write cycle.
  logic [31:0] ram [0:255];
  logic        ready_mode = 1'b1;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int n_vec  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .ABORT_DATA(32'hDEADBEEF)) dut (
    .clock(clock), .reset(reset),
    .p0_enable(p0_enable), .p0_read_or_write(p0_read_or_write),
    .p0_addr(p0_addr), .p0_write_data(p0_write_data),
    .p0_read_data(p0_read_data), .p0_ready(p0_ready),
    .p1_enable(p1_enable), .p1_read_or_write(p1_read_or_write),
    .p1_addr(p1_addr), .p1_write_data(p1_write_data),
    .p1_read_data(p1_read_data), .p1_ready(p1_ready),
    .mem_enable(mem_enable), .mem_read_or_write(mem_read_or_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .bus_error(bus_error), .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  assign mem_ready     = ready_mode;
  assign mem_read_data = ram[mem_addr[9:2]];

  always @(posedge clock) begin
    if (pre_we)
      ram[pre_idx] <= pre_data;
    else if (mem_enable && !mem_read_or_write && mem_ready)
      ram[mem_addr[9:2]] <= mem_write_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic en, input logic rw,
                               input logic [31:0] addr, input logic [31:0] data);
    if (port == 0) begin
      p0_enable = en; p0_read_or_write = rw; p0_addr = addr; p0_write_data = data;
    end else begin
      p1_enable = en; p1_read_or_write = rw; p1_addr = addr; p1_write_data = data;
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Waits (bounded) for the given port's ready pulse; a missed pulse is a
  // failed comparison.
  task automatic waitReady(input int port, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clock);
      seen = (port == 0) ? p0_ready : p1_ready;
    end
    checkOutput({tag, "_ready"}, 32'(seen), 32'd1);
  endtask

  // One complete transaction on a port, released in the ready cycle.
  task automatic doAccess(input int port, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
    @(negedge clock);
    applyStimulus(port, 1'b1, rw, addr, data);
    waitReady(port, tag);
    applyStimulus(port, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int en_cycles;
    bit seen;
    logic [31:0] who;

    preload(8'd0, 32'h11111111);
    preload(8'd4, 32'h12345678);
    preload(8'd8, 32'h0BADF00D);
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_enable", 32'(mem_enable), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
    checkOutput("rst_p0_read_data", p0_read_data, 32'h0);

    $display("[TB] uncontended p0 read latency");
    applyStimulus(0, 1'b1, 1'b1, 32'h10, '0);
    @(negedge clock);
    checkOutput("t1_mem_enable", 32'(mem_enable), 32'd1);
    checkOutput("t1_mem_addr", mem_addr, 32'h10);
    checkOutput("t1_mem_rw", 32'(mem_read_or_write), 32'd1);
    checkOutput("t1_ready_early", 32'(p0_ready), 32'd0);
    @(negedge clock);
    checkOutput("t1_p0_ready", 32'(p0_ready), 32'd1);
    checkOutput("t1_p1_ready", 32'(p1_ready), 32'd0);
    checkOutput("t1_mem_enable_done", 32'(mem_enable), 32'd0);
    checkOutput("t1_p0_read_data", p0_read_data, 32'h12345678);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    $display("[TB] simultaneous p0 read / p1 write after reset");
    doReset();
    applyStimulus(0, 1'b1, 1'b1, 32'h0, '0);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D);
    @(negedge clock);
    checkOutput("t2_first_grant", 32'(grant), 32'd0);
    @(negedge clock);
    checkOutput("t2_p0_ready", 32'(p0_ready), 32'd1);
    checkOutput("t2_p0_read_data", p0_read_data, 32'h11111111);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t2_second_grant", 32'(grant), 32'd1);
    checkOutput("t2_mem_rw", 32'(mem_read_or_write), 32'd0);
    checkOutput("t2_mem_wdata", mem_write_data, 32'hCAFEF00D);
    @(negedge clock);
    checkOutput("t2_p1_ready", 32'(p1_ready), 32'd1);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    checkOutput("t2_ram_written", ram[8'h10], 32'hCAFEF00D);
    checkOutput("t2_p1_read_data", p1_read_data, 32'h0);

    $display("[TB] sustained contention");
    @(negedge clock);
    applyStimulus(0, 1'b1, 1'b1, 32'h10, '0);
    applyStimulus(1, 1'b1, 1'b1, 32'h20, '0);
    for (int i = 0; i < 6; i++) begin
      seen = 1'b0;
      who = 32'hFFFFFFFF;
      for (int k = 0; k < 12 && !seen; k++) begin
        @(negedge clock);
        if (p0_ready || p1_ready) begin
          seen = 1'b1;
          who = {30'd0, p0_ready, p1_ready};
        end
      end
      // 2'b10 means only p0 completed, 2'b01 only p1.
      checkOutput($sformatf("t3_turn%0d", i), who, (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);

    $display("[TB] watchdog abort");
    @(negedge clock);
    ready_mode = 1'b0;
    applyStimulus(1, 1'b1, 1'b1, 32'h20, '0);
    en_cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (mem_enable) en_cycles++;
      seen = p1_ready;
    end
    checkOutput("t4_p1_ready", 32'(seen), 32'd1);
    checkOutput("t4_enable_cycles", 32'(en_cycles), 32'd8);
    checkOutput("t4_abort_data", p1_read_data, 32'hDEADBEEF);
    checkOutput("t4_bus_error", 32'(bus_error), 32'd1);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    ready_mode = 1'b1;
    doAccess(0, 1'b1, 32'h10, '0, "t4_good_read");
    checkOutput("t4_good_data", p0_read_data, 32'h12345678);
    checkOutput("t4_sticky1", 32'(bus_error), 32'd1);
    doAccess(1, 1'b0, 32'h24, 32'h00000055, "t4_write");
    checkOutput("t4_write_keeps_rdata", p1_read_data, 32'hDEADBEEF);
    checkOutput("t4_sticky2", 32'(bus_error), 32'd1);

    $display("[TB] reset during access");
    @(negedge clock);
    ready_mode = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 32'h10, '0);
    repeat (2) @(negedge clock);
    checkOutput("t5_in_access", 32'(mem_enable), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t5_mem_enable", 32'(mem_enable), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
    checkOutput("t5_bus_error", 32'(bus_error), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    ready_mode = 1'b1;
    applyStimulus(1, 1'b1, 1'b1, 32'h20, '0);
    @(negedge clock);
    checkOutput("t5_tie_grant", 32'(grant), 32'd0);
    checkOutput("t5_tie_busy", 32'(busy), 32'd1);
    waitReady(0, "t5_p0");
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    waitReady(1, "t5_p1");
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    checkOutput("t5_p1_data", p1_read_data, 32'h0BADF00D);

    $display("[TB] fetch and load/store sequence");
    doAccess(1, 1'b0, 32'h80, 32'hA5A5A5A5, "t6_store");
    checkOutput("t6_ram", ram[8'h20], 32'hA5A5A5A5);
    doAccess(1, 1'b1, 32'h80, '0, "t6_load");
    checkOutput("t6_load_data", p1_read_data, 32'hA5A5A5A5);
    doAccess(0, 1'b1, 32'h80, '0, "t6_fetch");
    checkOutput("t6_fetch_data", p0_read_data, 32'hA5A5A5A5);
    checkOutput("t6_p1_unchanged", p1_read_data, 32'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
